pipeline_stage_register: RTL and testbench

Generic, parametrised pipeline stage register replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the core. It carries a data bundle and a control bundle between two stages with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` is registered and does not depend combinationally on `out_ready`. A synchronous flush inserts bubbles. While no valid entry is held, the control bundle is forced to a safe reset value, so downstream write enables are inactive.

---
 rtl/pipeline_stage_register.sv | 122 ++++++++++++
 tb/tb_pipeline_stage_register.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_register.sv
// Generic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, and control bundle forced to a bubble value while empty.
module pipeline_stage_register #(
   parameter int unsigned            DATA_WIDTH  = 128,
   parameter int unsigned            CTRL_WIDTH  = 16,
   parameter logic [CTRL_WIDTH-1:0]  CTRL_BUBBLE = {CTRL_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   state_t                next_state;
   logic                  accept;
   logic                  consume;
   logic                  load_main;
   logic                  load_skid;
   logic                  main_from_skid;
   logic [DATA_WIDTH-1:0] main_data;
   logic [CTRL_WIDTH-1:0] main_ctrl;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CTRL_WIDTH-1:0] skid_ctrl;

   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   // State register plus status flags decoded from the next state so they are flops.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         state     <= next_state;
         in_ready  <= (next_state != FULL);
         out_valid <= (next_state != EMPTY);
         occupancy <= next_state;
      end
   end

   // Next-state and entry-load decode; flush overrides every handshake outcome.
   always_comb begin
      next_state     = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               load_main  = 1'b1;
               next_state = ONE;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               next_state = FULL;
            end else if (consume) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               main_from_skid = 1'b1;
               next_state     = ONE;
            end
         end
         default: next_state = EMPTY;
      endcase
      if (flush) begin
         next_state     = EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   // Entry storage; flush leaves contents in place since out_valid masks them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         if (load_main) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
         end else if (main_from_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
         end
      end
   end

   assign out_data = main_data;
   assign out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed bench for pipeline_stage_register: queue scoreboard of accepted entries,
// checked against the head entry on every consume plus per-cycle status checks.
module tb_pipeline_stage_register;

   localparam int unsigned DW = 128;
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] BUBBLE = '0;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } entry_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;

   int     total = 0;
   int     bad   = 0;
   entry_t sb[$];

   pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_BUBBLE(BUBBLE)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
      return CW'(d[CW-1:0] ^ 16'hA5C3);
   endfunction

   // One clock cycle: drive inputs, check status/head vs model, update model, advance.
   task automatic cyc(input logic rst, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy, input logic fl);
      entry_t e;
      logic   acc;
      logic   cons;
      reset_n   = ~rst;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk("occupancy", DW'(occupancy), DW'(sb.size()));
      chk("in_ready",  DW'(in_ready),  DW'(sb.size() != 2));
      chk("out_valid", DW'(out_valid), DW'(sb.size() != 0));
      if (sb.size() == 0) chk("bubble_ctrl", DW'(out_ctrl), DW'(BUBBLE));
      acc  = iv && (sb.size() != 2);
      cons = ordy && (sb.size() != 0);
      if (cons && !rst && !fl) begin
         e = sb.pop_front();
         chk("out_data", out_data, e.d);
         chk("out_ctrl", DW'(out_ctrl), DW'(e.c));
      end
      if (rst || fl) sb.delete();
      else if (acc) begin
         e.d = d;
         e.c = c;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
      cyc(1'b0, iv, d, ctrl_of(d), ordy, fl);
   endtask

   task automatic chk_reset_vals();
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_in_ready",  DW'(in_ready), DW'(1));
      chk("rst_occupancy", DW'(occupancy), '0);
      chk("rst_out_ctrl",  DW'(out_ctrl), DW'(BUBBLE));
      chk("rst_out_data",  out_data, '0);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset held two cycles with upstream valid.
      cyc(1'b1, 1'b1, DW'(99), 16'hFFFF, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, DW'(99), 16'hFFFF, 1'b1, 1'b0);
      chk_reset_vals();

      // Streaming 1..8 with downstream always ready.
      for (int i = 1; i <= 8; i++) send(1'b1, DW'(i), 1'b1, 1'b0);
      send(1'b0, '0, 1'b1, 1'b0);

      // Backpressure: A, B fill the stage, C waits upstream.
      send(1'b1, DW'(32'hA), 1'b0, 1'b0);
      send(1'b1, DW'(32'hB), 1'b0, 1'b0);
      chk("bp_full_occ", DW'(occupancy), DW'(2));
      send(1'b1, DW'(32'hC), 1'b0, 1'b0);
      send(1'b1, DW'(32'hC), 1'b1, 1'b0);
      send(1'b1, DW'(32'hC), 1'b1, 1'b0);
      send(1'b0, '0, 1'b1, 1'b0);
      chk("bp_drained", DW'(sb.size()), '0);

      // Flush while FULL with upstream valid.
      send(1'b1, DW'(32'h21), 1'b0, 1'b0);
      send(1'b1, DW'(32'h22), 1'b0, 1'b0);
      send(1'b1, DW'(32'h23), 1'b1, 1'b1);
      chk("flush_out_valid", DW'(out_valid), '0);
      chk("flush_out_ctrl",  DW'(out_ctrl), DW'(BUBBLE));
      // Flush in ONE with a simultaneous accept: the incoming entry is killed.
      send(1'b1, DW'(32'h31), 1'b0, 1'b0);
      send(1'b1, DW'(32'h32), 1'b1, 1'b1);
      send(1'b1, DW'(32'h33), 1'b1, 1'b0);
      chk("post_flush_data", out_data, DW'(32'h33));
      send(1'b0, '0, 1'b1, 1'b0);

      // Bubble control: all-ones ctrl with no valid must not appear.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, DW'(32'h77), 16'hFFFF, 1'b1, 1'b0);
         chk("bubble_hold", DW'(out_ctrl), DW'(BUBBLE));
      end

      // Reset mid-operation from FULL, then fresh traffic.
      send(1'b1, DW'(32'h11), 1'b0, 1'b0);
      send(1'b1, DW'(32'h22), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      chk_reset_vals();
      send(1'b1, DW'(32'h33), 1'b0, 1'b0);
      send(1'b0, '0, 1'b1, 1'b0);
      send(1'b0, '0, 1'b1, 1'b0);
      chk("final_empty", DW'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
